axi_lite_uart: RTL and testbench

- Synthesizable AXI4-Lite UART peripheral: TX FIFO, RX FIFO, programmable baud divider, 8N1 framing.
- Sits directly downstream of the UART AXI-to-AXI-Lite converter in the SoC.
- Consumes the 32-bit AXI-Lite slave port and drives the `tx`/`rx` pins.
- Replaces the behavioural UART mock for synthesis targets.

---
 rtl/axi_lite_uart.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_axi_lite_uart.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_uart.sv
// AXI4-Lite UART: TX/RX FIFOs, programmable baud divider, 8N1 framing.
// Registers are decoded on addr[4:2]. Any offset not in the register map reads 0 and ignores writes.

module axi_lite_uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module axi_lite_uart #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned BAUD_DIV_RESET = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      tx,
    input  logic                      rx,
    output logic                      irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    localparam logic [2:0]  A_TXDATA = 3'd0, A_RXDATA = 3'd1, A_STATUS = 3'd2,
                            A_BAUD = 3'd3, A_IE = 3'd4;
    localparam logic [15:0] BAUD_INIT = 16'(BAUD_DIV_RESET);

    logic [15:0] baud_div;
    logic [1:0]  ie;
    logic        rx_overrun, frame_err;
    logic [31:0] rd_mux, status;
    logic [2:0]  wsel, rsel;
    logic        wr_hs, rd_hs, tx_push, tx_drop, rx_pop, ovr_set;
    logic        tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push, fe_set;
    logic [7:0]  tx_head, rx_head;
    logic        unused_bits;

    assign unused_bits = ^{awaddr[AXI_ADDR_WIDTH-1:5], awaddr[1:0],
                           araddr[AXI_ADDR_WIDTH-1:5], araddr[1:0], wdata[31:16], wstrb[3:1]};

    assign wsel    = awaddr[4:2];
    assign rsel    = araddr[4:2];
    assign wr_hs   = awvalid & wvalid & ~bvalid & ~rst;
    assign awready = wr_hs;
    assign wready  = wr_hs;
    assign arready = ~rvalid & ~rst;
    assign rd_hs   = arvalid & arready;
    assign rresp   = 2'b00;

    // A push into a full TX FIFO survives when the FSM pops in the same cycle.
    assign tx_push = wr_hs && (wsel == A_TXDATA) && wstrb[0];
    assign tx_drop = tx_push & tx_full & ~tx_pop;
    assign rx_pop  = rd_hs && (rsel == A_RXDATA);
    assign ovr_set = rx_push & rx_full & ~rx_pop;

    axi_lite_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(wdata[7:0]),
        .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    // --- TX serializer ---
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_n, tx_busy, tx_end;

    assign tx_busy = (tx_state != S_IDLE);
    assign tx_end  = (tx_cnt == tx_div - 16'd1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                tx_n     = 1'b1;
                if (!tx_empty) begin
                    tx_state_n = S_START;
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_div_n   = baud_div;
                    tx_n       = 1'b0;
                end
            end
            S_START: if (tx_end) begin
                tx_state_n = S_DATA;
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_n       = tx_shift[0];
            end
            S_DATA: if (tx_end) begin
                tx_cnt_n = '0;
                if (tx_bit == 3'd7) begin
                    tx_state_n = S_STOP;
                    tx_n       = 1'b1;
                end else begin
                    tx_bit_n = tx_bit + 3'd1;
                    tx_n     = tx_shift[tx_bit + 3'd1];
                end
            end
            default: if (tx_end) begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_state_n = S_START;
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_div_n   = baud_div;
                    tx_n       = 1'b0;
                end else begin
                    tx_state_n = S_IDLE;
                    tx_n       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= BAUD_INIT;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    // --- RX deserializer: rx_s1/rx_s2 synchronize, rx_prev finds the falling edge ---
    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_prev, rx_end;

    assign rx_end = (rx_cnt == rx_div - 16'd1);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) begin
                    rx_state_n = S_START;
                    rx_div_n   = baud_div;
                end
            end
            S_START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                if (rx_bit == 3'd7) rx_state_n = S_STOP;
                else                rx_bit_n   = rx_bit + 3'd1;
            end
            default: if (rx_end) begin
                rx_state_n = S_IDLE;
                rx_push    = rx_s2;
                fe_set     = ~rx_s2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_s1, rx_s2, rx_prev} <= 3'b111;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= BAUD_INIT;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            {rx_s1, rx_s2, rx_prev} <= {rx, rx_s1, rx_s2};
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    axi_lite_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
        .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // --- Register file and AXI response channels ---
    assign status = {25'b0, frame_err, rx_overrun, tx_busy, rx_full, ~rx_empty, tx_empty, tx_full};

    always_comb begin
        rd_mux = '0;
        case (rsel)
            A_RXDATA: rd_mux = {23'b0, ~rx_empty, rx_empty ? 8'h00 : rx_head};
            A_STATUS: rd_mux = status;
            A_BAUD:   rd_mux = {16'b0, baud_div};
            A_IE:     rd_mux = {30'b0, ie};
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
            rvalid     <= 1'b0;
            rdata      <= '0;
            baud_div   <= BAUD_INIT;
            ie         <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_hs) begin
                bvalid <= 1'b1;
                bresp  <= tx_drop ? 2'b10 : 2'b00;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
            if (rd_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
            if (wr_hs && wsel == A_BAUD) baud_div <= (wdata[15:0] < 16'd8) ? 16'd8 : wdata[15:0];
            if (wr_hs && wsel == A_IE)   ie       <= wdata[1:0];
            // A same-cycle set beats the write-1-to-clear.
            rx_overrun <= ovr_set | (rx_overrun & ~(wr_hs && wsel == A_STATUS && wdata[5]));
            frame_err  <= fe_set  | (frame_err  & ~(wr_hs && wsel == A_STATUS && wdata[6]));
            irq        <= (~rx_empty & ie[0]) | (tx_empty & ie[1]);
        end
    end
endmodule

// File: tb/tb_axi_lite_uart.sv
// Directed/randomized bench for axi_lite_uart: TX waveform, FIFO limits, RX framing, errors,
// AXI back-pressure and mid-frame reset, checked against a byte-level reference model.

module tb_axi_lite_uart;
    localparam int DEPTH = 16;
    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0, rst = 1'b1;
    logic [63:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, tx, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        rx = 1'b1;

    int checks = 0, failures = 0;
    int cyc = 0;
    logic tx_at [0:32767];

    axi_lite_uart #(.AXI_ADDR_WIDTH(64), .FIFO_DEPTH(DEPTH), .BAUD_DIV_RESET(868)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 32768) tx_at[cyc] = tx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit k (0=start .. 9=stop) of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [9:0] w;
        w = {1'b1, b, 1'b0};
        return w[k];
    endfunction

    // hs = value of cyc right after the posedge that completes the AW/W handshake.
    task automatic axi_wr(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int hs);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 64) begin @(negedge clk); #1; n++; end
        check("aw_handshake", {31'b0, awready}, 32'd1);
        hs = cyc + 1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        #1;
        n = 0;
        while (!bvalid && n < 64) begin @(negedge clk); #1; n++; end
        check("b_valid", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [63:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 64) begin @(negedge clk); #1; n++; end
        check("ar_handshake", {31'b0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        n = 0;
        while (!rvalid && n < 64) begin @(negedge clk); #1; n++; end
        check("r_valid", {31'b0, rvalid}, 32'd1);
        d = rdata;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx = (k == 9) ? stop : frame_bit(b, k);
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [7:0]  bytes [18];
        logic [7:0]  exp_tx [$];
        logic [7:0]  exp_rx [$];
        int          h, h0, fill, errs, held;
        logic        ovr_exp;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_valid_ready", {28'b0, bvalid, rvalid, awready | wready, arready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        axi_rd(64'h0C, d); check("baud_reset", d, 32'd868);
        axi_rd(64'h08, d); check("status_reset", d, 32'h02);

        // Register access
        axi_wr(64'h0C, 32'd3, 4'hF, resp, h);  check("baud_wr_resp", {30'b0, resp}, 32'd0);
        axi_rd(64'h0C, d); check("baud_min_clamp", d, 32'd8);
        axi_wr(64'hFFFF_0000_0000_000C, DIV, 4'hF, resp, h);
        axi_rd(64'h0C, d); check("baud_upper_addr_ignored", d, DIV);
        axi_wr(64'h10, 32'h2, 4'hF, resp, h);
        @(negedge clk);
        check("irq_tx_empty", {31'b0, irq}, 32'd1);
        axi_rd(64'h10, d); check("ie_readback", d, 32'h2);
        axi_wr(64'h10, 32'h0, 4'hF, resp, h);
        @(negedge clk);
        check("irq_off", {31'b0, irq}, 32'd0);
        axi_wr(64'h14, 32'hFFFF_FFFF, 4'hF, resp, h); check("unmapped_wr_resp", {30'b0, resp}, 32'd0);
        axi_rd(64'h14, d); check("unmapped_rd", d, 32'd0);
        axi_rd(64'h00, d); check("txdata_rd", d, 32'd0);
        axi_wr(64'h00, 32'hA5, 4'hE, resp, h); check("strb_suppress_resp", {30'b0, resp}, 32'd0);
        repeat (4) @(negedge clk);
        axi_rd(64'h08, d); check("strb_suppress_status", d, 32'h02);

        // Single TX frame 0x55
        axi_wr(64'h00, 32'h55, 4'hF, resp, h);
        check("tx55_resp", {30'b0, resp}, 32'd0);
        repeat (FRAME + 10) @(negedge clk);
        check("tx55_before_start", {31'b0, tx_at[h]}, 32'd1);
        errs = 0;
        for (int j = 0; j < FRAME; j++) if (tx_at[h + 1 + j] !== frame_bit(8'h55, j / DIV)) errs++;
        check("tx55_waveform", errs, 0);
        check("tx55_idle_after", {31'b0, tx_at[h + 1 + FRAME]}, 32'd1);
        axi_rd(64'h08, d); check("tx55_status_empty", d, 32'h02);

        // TX burst: one frame in flight, then 17 writes against a 16-deep FIFO
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        axi_wr(64'h00, {24'b0, bytes[0]}, 4'hF, resp, h0);
        exp_tx.push_back(bytes[0]);
        fill = 0;
        for (int i = 1; i < 18; i++) begin
            axi_wr(64'h00, {24'b0, bytes[i]}, 4'hF, resp, h);
            check("burst_resp", {30'b0, resp}, (fill == DEPTH) ? 32'd2 : 32'd0);
            if (fill < DEPTH) begin
                exp_tx.push_back(bytes[i]);
                fill++;
            end
        end
        repeat (exp_tx.size() * FRAME + 20) @(negedge clk);
        foreach (exp_tx[f]) begin
            errs = 0;
            for (int j = 0; j < FRAME; j++)
                if (tx_at[h0 + 1 + f * FRAME + j] !== frame_bit(exp_tx[f], j / DIV)) errs++;
            check("burst_frame", errs, 0);
        end
        check("burst_idle_after", {31'b0, tx_at[h0 + 1 + exp_tx.size() * FRAME]}, 32'd1);

        // RX single frame 0xA3
        send_rx(8'hA3, 1'b1);
        repeat (6) @(negedge clk);
        axi_rd(64'h08, d); check("rx_a3_status", d, 32'h06);
        axi_rd(64'h04, d); check("rx_a3_data", d, 32'h1A3);
        axi_rd(64'h04, d); check("rx_empty_read", d, 32'h000);
        axi_rd(64'h08, d); check("rx_valid_cleared", d, 32'h02);

        // RX overrun: 17 frames, no reads
        ovr_exp = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_rx(b, 1'b1);
            repeat (2) @(negedge clk);
            if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
            else                       ovr_exp = 1'b1;
        end
        repeat (6) @(negedge clk);
        axi_rd(64'h08, d); check("ovr_status", d, 32'h0E | (ovr_exp ? 32'h20 : 32'h0));
        axi_wr(64'h10, 32'h1, 4'hF, resp, h);
        @(negedge clk);
        check("irq_rx_valid", {31'b0, irq}, 32'd1);
        axi_wr(64'h10, 32'h0, 4'hF, resp, h);
        while (exp_rx.size() > 0) begin
            axi_rd(64'h04, d);
            check("ovr_data", d, {23'b0, 1'b1, exp_rx.pop_front()});
        end
        axi_rd(64'h04, d); check("ovr_drained", d, 32'h0);
        axi_rd(64'h08, d); check("ovr_sticky", d, 32'h22);
        axi_wr(64'h08, 32'h20, 4'hF, resp, h);
        axi_rd(64'h08, d); check("ovr_w1c", d, 32'h02);

        // Frame error, then glitch rejection
        send_rx(8'($urandom), 1'b0);
        repeat (20) @(negedge clk);
        axi_rd(64'h08, d); check("frame_err_status", d, 32'h42);
        axi_wr(64'h08, 32'h40, 4'hF, resp, h);
        axi_rd(64'h08, d); check("frame_err_w1c", d, 32'h02);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        axi_rd(64'h08, d); check("glitch_status", d, 32'h02);
        axi_rd(64'h04, d); check("glitch_no_byte", d, 32'h0);

        // B channel back-pressure: second write must wait
        @(negedge clk);
        awaddr = 64'h10; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("hold_aw_first", {31'b0, awready}, 32'd1);
        @(negedge clk);
        wdata = 32'h2;
        held = 0;
        repeat (10) begin
            #1;
            if (bvalid && !awready && !wready) held++;
            @(negedge clk);
        end
        check("hold_bvalid", held, 10);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_rd(64'h10, d); check("hold_second_write_blocked", d, 32'h1);

        // R channel back-pressure
        @(negedge clk);
        araddr = 64'h10; arvalid = 1'b1;
        #1;
        check("hold_ar_first", {31'b0, arready}, 32'd1);
        @(negedge clk);
        araddr = 64'h0C;
        held = 0;
        repeat (10) begin
            #1;
            if (rvalid && !arready && rdata == 32'h1) held++;
            @(negedge clk);
        end
        check("hold_rvalid", held, 10);
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;

        // Reset in the middle of a TX frame
        axi_wr(64'h00, 32'h00, 4'hF, resp, h);
        repeat (50) @(negedge clk);
        check("pre_rst_tx", {31'b0, tx}, {31'b0, frame_bit(8'h00, (cyc - h - 1) / DIV)});
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_high", {31'b0, tx}, 32'd1);
        check("rst_mid_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        axi_rd(64'h08, d); check("rst_mid_status", d, 32'h02);
        axi_rd(64'h0C, d); check("rst_mid_baud", d, 32'd868);
        axi_rd(64'h10, d); check("rst_mid_ie", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
